apb_reg_slave: RTL and testbench

Parametrised APB4 slave register bank with a configurable number of registers, data width, inserted wait states, per-byte write strobes and error signalling. It sits behind an APB master on the `pclk` domain. It exposes register contents and write pulses to local hardware, and returns hardware-supplied values for read-only registers.

---
 rtl/apb_reg_slave.sv | 180 ++++++++++++++++++
 tb/tb_apb_reg_slave.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_reg_slave.sv
`default_nettype none
// ============================================================================
// Module   : apb_reg_slave
// Purpose  : Parametrised APB4 slave register bank. It supports programmable
//            wait states, per-byte write strobes and read-only registers
//            sourced from hardware. Error responses cover out-of-range,
//            misaligned and read-only-write accesses.
// Ports    : pclk/preset          - bus clock, synchronous active-high reset
//            paddr/psel/penable/
//            pwrite/pwdata/pstrb  - APB4 request
//            pready/prdata/pslverr- APB4 response (prdata/pslverr gated by pready)
//            reg_q                - flattened register contents
//            ro_d                 - hardware values for read-only registers
//            wr_pulse             - one-cycle pulse per successfully written reg
// Revision : 1.0 - initial release
// ============================================================================
module apb_reg_slave #(
    parameter int                  ADDR_WIDTH  = 32,
    parameter int                  DATA_WIDTH  = 32,
    parameter int                  NUM_REGS    = 8,
    parameter int                  WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
    input  logic                           pclk,
    input  logic                           preset,
    input  logic [ADDR_WIDTH-1:0]          paddr,
    input  logic                           psel,
    input  logic                           penable,
    input  logic                           pwrite,
    input  logic [DATA_WIDTH-1:0]          pwdata,
    input  logic [DATA_WIDTH/8-1:0]        pstrb,
    output logic                           pready,
    output logic [DATA_WIDTH-1:0]          prdata,
    output logic                           pslverr,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_d,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int         c_LANES = DATA_WIDTH / 8;
    localparam int         c_OFF_W = $clog2(c_LANES);
    localparam int         c_SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [3:0] c_WAIT  = 4'(WAIT_STATES);

    // The APB setup cycle is the one in which IDLE observes psel & !penable;
    // the wait counter is loaded on that edge so the first penable cycle is
    // already an access cycle (transfer = WAIT_STATES + 2 cycles).
    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t                         r_state;
    logic [3:0]                     r_cnt;

    logic [63:0]                    w_index_ext;
    logic [c_SEL_W-1:0]             w_sel;
    logic                           w_in_range;
    logic                           w_misaligned;
    logic                           w_ro_hit;
    logic                           w_err;
    logic                           w_pready;
    logic                           w_commit;
    logic [DATA_WIDTH-1:0]          w_rd_word;
    logic [NUM_REGS*DATA_WIDTH-1:0] w_regs;
    logic [NUM_REGS-1:0]            w_pulse;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign w_index_ext = 64'(paddr[ADDR_WIDTH-1:c_OFF_W]);
    assign w_in_range  = (w_index_ext < 64'(NUM_REGS));
    assign w_sel       = w_index_ext[c_SEL_W-1:0];

    generate
        if (c_OFF_W > 0) begin : g_offset
            assign w_misaligned = |paddr[c_OFF_W-1:0];
        end else begin : g_no_offset
            assign w_misaligned = 1'b0;
        end
    endgenerate

    // Read mux and read-only lookup over the selected register
    always_comb begin
        w_rd_word = '0;
        w_ro_hit  = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_in_range && (w_sel == c_SEL_W'(i))) begin
                w_ro_hit  = RO_MASK[i];
                w_rd_word = RO_MASK[i] ? ro_d[i*DATA_WIDTH +: DATA_WIDTH]
                                       : w_regs[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_err = ~w_in_range | w_misaligned | (pwrite & w_ro_hit);

    // ------------------------------------------------------------------
    // Handshake. Gating with preset keeps every output at its reset value
    // while reset is held and discards a write completing under reset.
    // ------------------------------------------------------------------
    assign w_pready = (r_state == S_ACCESS) & psel & penable & (r_cnt == 4'd0) & ~preset;
    assign w_commit = w_pready & pwrite & ~w_err;

    assign pready   = w_pready;
    assign pslverr  = w_pready & w_err;
    assign prdata   = (w_pready & ~pwrite & ~w_err) ? w_rd_word : '0;
    assign reg_q    = preset ? '0 : w_regs;
    assign wr_pulse = preset ? '0 : w_pulse;

    // ------------------------------------------------------------------
    // Transfer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // psel & penable in IDLE is a protocol violation: ignored
                    if (psel && !penable) begin
                        r_state <= S_ACCESS;
                        r_cnt   <= c_WAIT;
                    end
                end
                S_ACCESS: begin
                    if (!psel) begin
                        r_state <= S_IDLE;          // aborted by the master
                    end else if (r_cnt != 4'd0) begin
                        r_cnt   <= r_cnt - 4'd1;
                    end else begin
                        r_state <= S_IDLE;          // completion cycle
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Register storage. Read-only registers carry no flops and read as 0
    // on reg_q; their read data comes from ro_d.
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
            if (RO_MASK[i]) begin : g_ro
                assign w_regs[i*DATA_WIDTH +: DATA_WIDTH] = '0;
                assign w_pulse[i]                         = 1'b0;
            end else begin : g_rw
                logic [DATA_WIDTH-1:0] r_q;
                logic                  r_pulse;
                logic                  w_hit;

                assign w_hit = w_in_range & (w_sel == c_SEL_W'(i));

                always_ff @(posedge pclk) begin
                    if (preset) begin
                        r_q     <= '0;
                        r_pulse <= 1'b0;
                    end else begin
                        r_pulse <= w_commit & w_hit;
                        if (w_commit && w_hit) begin
                            for (int b = 0; b < c_LANES; b++) begin
                                if (pstrb[b]) begin
                                    r_q[b*8 +: 8] <= pwdata[b*8 +: 8];
                                end
                            end
                        end
                    end
                end

                assign w_regs[i*DATA_WIDTH +: DATA_WIDTH] = r_q;
                assign w_pulse[i]                         = r_pulse;
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_apb_reg_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_reg_slave
// Purpose  : Self-checking bench for apb_reg_slave. Two instances share one
//            bus (separate psel): instance 0 has no wait states, instance 1
//            has three. Register 7 is read-only on both. A register-array
//            model predicts read data, error responses, pulses and contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_reg_slave;

    localparam int c_NREGS = 8;

    logic                    clk;
    logic                    preset;
    logic [31:0]             paddr;
    logic [1:0]              psel;
    logic                    penable;
    logic                    pwrite;
    logic [31:0]             pwdata;
    logic [3:0]              pstrb;
    logic [255:0]            ro_d;
    logic [1:0]              pready_w;
    logic [1:0]              pslverr_w;
    logic [1:0][31:0]        prdata_w;
    logic [1:0][255:0]       regq_w;
    logic [1:0][7:0]         pulse_w;

    logic [31:0]             mdl [2][c_NREGS];
    int                      n_total;
    int                      n_bad;

    apb_reg_slave #(
        .ADDR_WIDTH (32), .DATA_WIDTH (32), .NUM_REGS (8),
        .WAIT_STATES(0),  .RO_MASK    (8'h80)
    ) u_dut0 (
        .pclk(clk), .preset(preset), .paddr(paddr), .psel(psel[0]),
        .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready_w[0]), .prdata(prdata_w[0]), .pslverr(pslverr_w[0]),
        .reg_q(regq_w[0]), .ro_d(ro_d), .wr_pulse(pulse_w[0])
    );

    apb_reg_slave #(
        .ADDR_WIDTH (32), .DATA_WIDTH (32), .NUM_REGS (8),
        .WAIT_STATES(3),  .RO_MASK    (8'h80)
    ) u_dut1 (
        .pclk(clk), .preset(preset), .paddr(paddr), .psel(psel[1]),
        .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready_w[1]), .prdata(prdata_w[1]), .pslverr(pslverr_w[1]),
        .reg_q(regq_w[1]), .ro_d(ro_d), .wr_pulse(pulse_w[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int waits_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic logic [255:0] exp_regq(input int d);
        logic [255:0] v;
        for (int i = 0; i < c_NREGS; i++) v[i*32 +: 32] = mdl[d][i];
        return v;
    endfunction

    task automatic clear_model();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < c_NREGS; i++) mdl[d][i] = 32'h0;
    endtask

    // Full transfer starting at a cycle boundary (just after posedge).
    // Returns just after the commit edge, with psel released.
    task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb);
        int          wcnt;
        bit          done;
        bit          err;
        logic [31:0] idx;
        logic [31:0] exp_rd;
        logic [7:0]  exp_pulse;
        idx    = addr >> 2;
        err    = (idx >= 32'(c_NREGS)) || (addr[1:0] != 2'b00) || (wr && idx == 32'd7);
        exp_rd = 32'h0;
        if (!err) exp_rd = (idx == 32'd7) ? ro_d[7*32 +: 32] : mdl[d][idx[2:0]];

        psel[d] = 1'b1; penable = 1'b0; pwrite = wr;
        paddr   = addr; pwdata  = data; pstrb  = strb;
        @(posedge clk); #1;
        penable = 1'b1;
        wcnt = 0;
        done = 1'b0;
        while (!done && wcnt < 40) begin
            @(negedge clk);
            if (pready_w[d]) done = 1'b1;
            else begin
                @(posedge clk); #1;
                wcnt++;
            end
        end
        if (!done) begin
            check("timeout", 256'd0, 256'd1);
            psel = 2'b00; penable = 1'b0;
            return;
        end
        check("wait_cycles", 256'(wcnt), 256'(waits_of(d)));
        check("pslverr", 256'(pslverr_w[d]), 256'(err));
        if (!wr) check("prdata", 256'(prdata_w[d]), 256'(exp_rd));

        exp_pulse = 8'h00;
        if (wr && !err) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) mdl[d][idx[2:0]][b*8 +: 8] = data[b*8 +: 8];
            exp_pulse = 8'h01 << idx[2:0];
        end
        @(posedge clk); #1;
        check("wr_pulse", 256'(pulse_w[d]), 256'(exp_pulse));
        check("reg_q", regq_w[d], exp_regq(d));
        psel = 2'b00; penable = 1'b0;
    endtask

    task automatic idle_check(input int d);
        @(posedge clk); #1;
        check("pulse_clear", 256'(pulse_w[d]), 256'd0);
        check("idle_pready", 256'(pready_w[d]), 256'd0);
    endtask

    initial begin
        int          d;
        bit          wr;
        logic [31:0] addr;
        n_total = 0;
        n_bad   = 0;
        clear_model();
        preset = 1'b1; psel = 2'b00; penable = 1'b0; pwrite = 1'b0;
        paddr  = '0;   pwdata = '0;  pstrb = '0;
        ro_d   = {32'h0000CAFE, 224'h0};
        for (int i = 0; i < 7; i++) ro_d[i*32 +: 32] = $urandom;

        // Reset: 3 cycles, checked while held and after release
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rst_pready",  256'(pready_w[k]),  256'd0);
            check("rst_prdata",  256'(prdata_w[k]),  256'd0);
            check("rst_pslverr", 256'(pslverr_w[k]), 256'd0);
            check("rst_regq",    regq_w[k],          256'd0);
            check("rst_pulse",   256'(pulse_w[k]),   256'd0);
        end
        @(posedge clk); #1;
        preset = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check("post_rst_regq",  regq_w[k],        256'd0);
            check("post_rst_pulse", 256'(pulse_w[k]), 256'd0);
        end

        // Zero-wait write, back-to-back read
        xfer(0, 1'b1, 32'h08, 32'hDEADBEEF, 4'hF);
        check("deadbeef_reg2", 256'(regq_w[0][95:64]), 256'(32'hDEADBEEF));
        xfer(0, 1'b0, 32'h08, 32'h0, 4'h0);

        // Byte strobes
        xfer(0, 1'b1, 32'h04, 32'h11223344, 4'hF);
        xfer(0, 1'b1, 32'h04, 32'hAABBCCDD, 4'b0101);
        check("strb_reg1", 256'(regq_w[0][63:32]), 256'(32'h11BB33DD));
        idle_check(0);

        // pstrb = 0 still pulses
        xfer(0, 1'b1, 32'h10, 32'h12345678, 4'h0);

        // Wait states on instance 1
        xfer(1, 1'b0, 32'h00, 32'h0, 4'h0);
        xfer(1, 1'b1, 32'h0C, 32'hCAFEF00D, 4'hF);
        xfer(1, 1'b0, 32'h0C, 32'h0, 4'h0);

        // Errors and read-only register
        xfer(0, 1'b0, 32'h1C, 32'h0, 4'h0);
        xfer(0, 1'b1, 32'h1C, 32'hFFFFFFFF, 4'hF);
        xfer(0, 1'b0, 32'h20, 32'h0, 4'h0);
        xfer(0, 1'b1, 32'h20, 32'h55555555, 4'hF);
        xfer(0, 1'b0, 32'h02, 32'h0, 4'h0);
        xfer(0, 1'b1, 32'h02, 32'h66666666, 4'hF);
        xfer(1, 1'b1, 32'h1C, 32'h77777777, 4'hF);

        // Abort: psel dropped during the 2nd wait cycle of a write to 0x00
        psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h00; pwdata = 32'h5A5A5A5A; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        check("abort_wait1", 256'(pready_w[1]), 256'd0);
        @(posedge clk); #1;
        psel = 2'b00; penable = 1'b0;
        @(posedge clk); #1;
        check("abort_pulse", 256'(pulse_w[1]), 256'd0);
        check("abort_regq",  regq_w[1], exp_regq(1));
        // psel & penable without setup must be ignored from IDLE
        psel[1] = 1'b1; penable = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("violation_pready", 256'(pready_w[1]), 256'd0);
            @(posedge clk); #1;
        end
        psel = 2'b00; penable = 1'b0;
        check("abort_regq_after", regq_w[1], exp_regq(1));
        xfer(1, 1'b0, 32'h00, 32'h0, 4'h0);

        // Randomized traffic on both instances
        for (int t = 0; t < 80; t++) begin
            d    = int'($urandom_range(0, 1));
            wr   = 1'($urandom_range(0, 1));
            addr = 32'($urandom_range(0, 9)) << 2;
            if ($urandom_range(0, 7) == 0) addr = addr | 32'($urandom_range(1, 3));
            if ($urandom_range(0, 15) == 0) addr = $urandom;
            if ($urandom_range(0, 5) == 0) ro_d[7*32 +: 32] = $urandom;
            xfer(d, wr, addr, $urandom, 4'($urandom_range(0, 15)));
        end
        idle_check(0);
        idle_check(1);

        // Reset asserted in the completion cycle of a zero-wait write
        psel[0] = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h0C; pwdata = 32'h0BADF00D; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        preset  = 1'b1;
        @(negedge clk);
        check("rstc_pready",  256'(pready_w[0]),  256'd0);
        check("rstc_prdata",  256'(prdata_w[0]),  256'd0);
        check("rstc_pslverr", 256'(pslverr_w[0]), 256'd0);
        check("rstc_regq",    regq_w[0],          256'd0);
        check("rstc_pulse",   256'(pulse_w[0]),   256'd0);
        @(posedge clk); #1;
        preset = 1'b0; psel = 2'b00; penable = 1'b0;
        clear_model();
        #1;
        check("rstc_regq_after0", regq_w[0], exp_regq(0));
        check("rstc_regq_after1", regq_w[1], exp_regq(1));
        check("rstc_pulse_after", 256'(pulse_w[0]), 256'd0);
        idle_check(0);
        xfer(0, 1'b0, 32'h0C, 32'h0, 4'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
